// File: rtl/rnn_cell_param_if.sv
// Start/input handshake and memory bus of the recurrent cell.
interface rnn_cell_param_if #(
    parameter int unsigned XW = 32,
    parameter int unsigned DW = 20,
    parameter int unsigned AW = 17
);
    logic          ready;
    logic          act_mode;
    logic [XW-1:0] idata;
    logic [DW-1:0] mdata_r;
    logic          busy;
    logic          i_en;
    logic          mce;
    logic [AW-1:0] maddr;
    logic [2:0]    msel;
    logic [DW-1:0] mdata_w;

    modport master (
        input  ready, act_mode, idata, mdata_r,
        output busy, i_en, mce, maddr, msel, mdata_w
    );
    modport slave (
        output ready, act_mode, idata, mdata_r,
        input  busy, i_en, mce, maddr, msel, mdata_w
    );
endinterface

// File: rtl/rnn_cell_param.sv
// Fixed-point recurrent cell: h_new[j] = act(b1 + Whh*h_old + Wxh*x + b2), one row at a time,
// weights streamed from external memory, results written back per timestep.
module rnn_cell_param #(
    parameter int unsigned H    = 64,
    parameter int unsigned XW   = 32,
    parameter int unsigned DW   = 20,
    parameter int unsigned FRAC = 16,
    parameter int unsigned TW   = 11,
    parameter int unsigned AW   = 17
) (
    input logic              clk,
    input logic              reset,
    rnn_cell_param_if.master bus
);
    localparam int unsigned LH   = $clog2(H);
    localparam int unsigned LM   = $clog2((H > XW) ? H : XW);
    localparam int unsigned ACCW = 2 * DW + LH + 2;
    localparam int unsigned NF   = H + XW + 2;
    localparam int unsigned CW   = $clog2(NF + 1);
    localparam logic signed [ACCW-1:0] ONE     = ACCW'(1) << FRAC;
    localparam logic signed [ACCW-1:0] NEG_ONE = -ONE;

    typedef enum logic [2:0] {IDLE, CNT, ROW, WRITE, SWAP} state_t;
    typedef enum logic [1:0] {K_BIAS, K_WHH, K_WXH} kind_t;

    state_t          state;
    logic            mode_q;
    logic [XW-1:0]   x_q;
    logic [TW-1:0]   t, t_cnt;
    logic [LH-1:0]   j;
    logic [CW-1:0]   cnt;
    logic            cnt_wait;
    logic [DW-1:0]   h_old [H];
    logic [DW-1:0]   h_new [H];

    // Fetch tag pipeline: stage 1 = address out, stage 2 = data back, stage 3 = product ready.
    logic            v1, v2, v3;
    kind_t           k1, k2;
    logic [LM-1:0]   i1, i2;
    logic            f1, f2, f3, l1, l2, l3;
    logic signed [ACCW-1:0] prod, acc;

    logic [2:0]      iss_sel;
    logic [AW-1:0]   iss_addr;
    kind_t           iss_kind;
    logic [LM-1:0]   iss_idx;
    logic            iss_first, iss_last;

    logic [DW-1:0]          h_sel;
    logic                   x_bit;
    logic signed [2*DW-1:0] mul;
    logic signed [ACCW-1:0] bias_al, term, acc_nx, rsh, rnd, lo;
    logic [DW-1:0]          res;

    // Row fetch schedule: b1, Whh[0..H-1], Wxh[0..XW-1], b2.
    always_comb begin
        iss_sel   = 3'b001;
        iss_kind  = K_BIAS;
        iss_idx   = '0;
        iss_addr  = AW'(j);
        iss_first = (cnt == '0);
        iss_last  = (cnt == CW'(NF - 1));
        if (cnt == '0) begin
            iss_sel = 3'b001;
        end else if (cnt <= CW'(H)) begin
            iss_sel  = 3'b010;
            iss_kind = K_WHH;
            iss_idx  = LM'(cnt - CW'(1));
        end else if (cnt <= CW'(H + XW)) begin
            iss_sel  = 3'b000;
            iss_kind = K_WXH;
            iss_idx  = LM'(cnt - CW'(H + 1));
        end else begin
            iss_sel = 3'b011;
        end
        if (iss_kind != K_BIAS) iss_addr = AW'({j, iss_idx});
    end

    // Terms are kept at 2*FRAC fraction bits so nothing is dropped before rounding.
    always_comb begin
        h_sel   = h_old[LH'(i2)];
        x_bit   = |(x_q & (XW'(1) << i2));
        mul     = $signed(bus.mdata_r) * $signed(h_sel);
        bias_al = {{(ACCW - DW - FRAC){bus.mdata_r[DW-1]}}, bus.mdata_r, {FRAC{1'b0}}};
        case (k2)
            K_WHH:   term = {{(ACCW - 2 * DW){mul[2*DW-1]}}, mul};
            K_WXH:   term = x_bit ? bias_al : '0;
            default: term = bias_al;
        endcase
        acc_nx = f3 ? prod : acc + prod;
        rsh    = acc_nx >>> FRAC;
        rnd    = rsh + ACCW'(acc_nx[FRAC-1]);
        lo     = mode_q ? '0 : NEG_ONE;
        if (rnd > ONE)     res = ONE[DW-1:0];
        else if (rnd < lo) res = lo[DW-1:0];
        else               res = rnd[DW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.i_en    <= 1'b0;
            bus.mce     <= 1'b0;
            bus.maddr   <= '0;
            bus.msel    <= '0;
            bus.mdata_w <= '0;
            mode_q      <= 1'b0;
            x_q         <= '0;
            t           <= '0;
            t_cnt       <= '0;
            j           <= '0;
            cnt         <= '0;
            cnt_wait    <= 1'b0;
            {v1, v2, v3} <= '0;
            k1 <= K_BIAS;  k2 <= K_BIAS;
            i1 <= '0;      i2 <= '0;
            {f1, f2, f3, l1, l2, l3} <= '0;
            prod <= '0;
            acc  <= '0;
            for (int n = 0; n < int'(H); n++) begin
                h_old[n] <= '0;
                h_new[n] <= '0;
            end
        end else begin
            bus.i_en <= 1'b0;
            if (bus.i_en) x_q <= bus.idata;
            v1 <= 1'b0;
            v2 <= v1;  k2 <= k1;  i2 <= i1;  f2 <= f1;  l2 <= l1;
            v3 <= v2;  f3 <= f2;  l3 <= l2;
            if (v2) prod <= term;
            if (v3) acc <= acc_nx;
            case (state)
                IDLE: begin
                    if (bus.ready) begin
                        state    <= CNT;
                        bus.busy <= 1'b1;
                        bus.mce  <= 1'b1;
                        bus.msel <= 3'b100;
                        bus.maddr <= '0;
                        mode_q   <= bus.act_mode;
                        cnt_wait <= 1'b0;
                        for (int n = 0; n < int'(H); n++) begin
                            h_old[n] <= '0;
                            h_new[n] <= '0;
                        end
                    end
                end
                CNT: begin
                    cnt_wait <= 1'b1;
                    if (cnt_wait) begin
                        t_cnt <= bus.mdata_r[TW-1:0];
                        t     <= '0;
                        j     <= '0;
                        cnt   <= '0;
                        if (bus.mdata_r[TW-1:0] == '0) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            bus.mce  <= 1'b0;
                            bus.msel <= '0;
                        end else begin
                            state    <= ROW;
                            bus.i_en <= 1'b1;
                        end
                    end
                end
                ROW: begin
                    if (cnt != CW'(NF)) begin
                        cnt       <= cnt + CW'(1);
                        bus.msel  <= iss_sel;
                        bus.maddr <= iss_addr;
                        v1 <= 1'b1;
                        k1 <= iss_kind;
                        i1 <= iss_idx;
                        f1 <= iss_first;
                        l1 <= iss_last;
                    end
                    if (v3 && l3) begin
                        state       <= WRITE;
                        bus.msel    <= 3'b101;
                        bus.maddr   <= AW'({t, j});
                        bus.mdata_w <= res;
                        h_new[j]    <= res;
                    end
                end
                WRITE: begin
                    bus.msel    <= '0;
                    bus.maddr   <= '0;
                    bus.mdata_w <= '0;
                    cnt         <= '0;
                    if (j == LH'(H - 1)) begin
                        state <= SWAP;
                    end else begin
                        j     <= j + LH'(1);
                        state <= ROW;
                    end
                end
                SWAP: begin
                    h_old <= h_new;
                    t     <= t + TW'(1);
                    j     <= '0;
                    if (t + TW'(1) == t_cnt) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.mce  <= 1'b0;
                    end else begin
                        state    <= ROW;
                        bus.i_en <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
